// File: rtl/sampa_pon_pkg.sv
// Shared types and defaults for the SAMPA power-on sequencer.
// State encodings are visible to software through state_o.
package sampa_pon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEL      = 3'd1,
    S_PG_WAIT  = 3'd2,
    S_SETTLE   = 3'd3,
    S_RST_HOLD = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  localparam int CHIP_IDX_W = 4;

  localparam int DEF_N_CHIP   = 4;
  localparam int DEF_CNT_W    = 24;
  localparam int DEF_T_PG_TMO = 100000;
  localparam int DEF_T_SETTLE = 10000;
  localparam int DEF_T_RST    = 1000;

  function automatic logic [CHIP_IDX_W-1:0] lowest_set(
    input logic [15:0] v
  );
    logic [CHIP_IDX_W-1:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = CHIP_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sampa_pon_delay_cnt.sv
// Shared wait counter: clear, count-enable and terminal-count
// compare against a limit chosen by the current wait state.
module sampa_pon_delay_cnt #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/sampa_pon_sequencer.sv
// Brings SAMPA chips up one at a time: rail, power-good, settle,
// reset release, PON. Optional macro: SAMPA_PON_PG_MONITOR_EN.
module sampa_pon_sequencer
  import sampa_pon_pkg::*;
#(
  parameter int N_CHIP   = DEF_N_CHIP,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_PG_TMO = DEF_T_PG_TMO,
  parameter int T_SETTLE = DEF_T_SETTLE,
  parameter int T_RST    = DEF_T_RST
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_CHIP-1:0]     chip_mask,
  input  logic [N_CHIP-1:0]     pwr_good,
  output logic [N_CHIP-1:0]     pwr_en,
  output logic [N_CHIP-1:0]     sampa_rst,
  output logic [N_CHIP-1:0]     sampa_pon,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CHIP_IDX_W-1:0] err_chip,
  output logic [2:0]            state_o
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (N_CHIP < 1 || N_CHIP > 16) begin : g_bad_n
    $error("N_CHIP must be 1..16");
  end
  if (T_PG_TMO < 1 || longint'(T_PG_TMO) >= CNT_LIM) begin : g_bad_pg
    $error("T_PG_TMO out of range");
  end
  if (T_SETTLE < 1 || longint'(T_SETTLE) >= CNT_LIM) begin : g_bad_st
    $error("T_SETTLE out of range");
  end
  if (T_RST < 1 || longint'(T_RST) >= CNT_LIM) begin : g_bad_rst
    $error("T_RST out of range");
  end

  localparam logic [CNT_W-1:0] LIM_PG  = CNT_W'(T_PG_TMO - 1);
  localparam logic [CNT_W-1:0] LIM_ST  = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] LIM_RST = CNT_W'(T_RST - 1);
  localparam logic [CHIP_IDX_W-1:0] LAST = CHIP_IDX_W'(N_CHIP - 1);

  state_t                state_q, state_d;
  logic [CHIP_IDX_W-1:0] idx_q, idx_d;
  logic [N_CHIP-1:0]     mask_q, mask_d;
  logic [N_CHIP-1:0]     en_q, en_d;
  logic [N_CHIP-1:0]     srst_q, srst_d;
  logic [N_CHIP-1:0]     pon_q, pon_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CHIP_IDX_W-1:0] ec_q, ec_d;

  logic [N_CHIP-1:0] sel;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_lim, cnt_val;

`ifdef SAMPA_PON_PG_MONITOR_EN
  // Chips whose power-good has been confirmed and is now watched.
  logic [N_CHIP-1:0]     good_q, good_d;
  logic [N_CHIP-1:0]     fault, kbit;
  logic [CHIP_IDX_W-1:0] kidx;
  assign fault = good_q & ~pwr_good;
  assign kidx  = lowest_set(16'(fault));
  assign kbit  = N_CHIP'(1) << kidx;
`endif

  assign sel = N_CHIP'(1) << idx_q;

  sampa_pon_delay_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_lim),
    .count (cnt_val),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    en_d    = en_q;
    srst_d  = srst_q;
    pon_d   = pon_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ec_d    = ec_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cnt_lim = '0;
`ifdef SAMPA_PON_PG_MONITOR_EN
    good_d  = good_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = chip_mask;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (|(mask_q & sel)) begin
          en_d    = en_q | sel;
          cnt_clr = 1'b1;
          state_d = S_PG_WAIT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_PG_WAIT: begin
        cnt_lim = LIM_PG;
        if (|(pwr_good & sel)) begin
          cnt_clr = 1'b1;
          state_d = S_SETTLE;
`ifdef SAMPA_PON_PG_MONITOR_EN
          good_d  = good_q | sel;
`endif
        end else if (cnt_tc) begin
          en_d    = en_q & ~sel;
          err_d   = 1'b1;
          ec_d    = idx_q;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = S_ERROR;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      S_SETTLE: begin
        cnt_lim = LIM_ST;
        if (cnt_tc) begin
          srst_d  = srst_q & ~sel;
          cnt_clr = 1'b1;
          state_d = S_RST_HOLD;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      S_RST_HOLD: begin
        cnt_lim = LIM_RST;
        if (cnt_tc) begin
          pon_d   = pon_q | sel;
          cnt_clr = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + CHIP_IDX_W'(1);
          state_d = S_SEL;
        end
      end
      S_DONE: begin
      end
      S_ERROR: begin
      end
    endcase
`ifdef SAMPA_PON_PG_MONITOR_EN
    if (|fault && state_q != S_IDLE && state_q != S_ERROR) begin
      en_d    = en_q & ~kbit;
      pon_d   = pon_q & ~kbit;
      srst_d  = srst_q | kbit;
      good_d  = good_q & ~kbit;
      err_d   = 1'b1;
      ec_d    = kidx;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
      state_d = S_ERROR;
    end
`endif
    // Abort outranks start and any monitor fault.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      en_d    = '0;
      srst_d  = '1;
      pon_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ec_d    = '0;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
`ifdef SAMPA_PON_PG_MONITOR_EN
      good_d  = '0;
`endif
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      srst_q  <= '1;
      pon_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ec_q    <= '0;
`ifdef SAMPA_PON_PG_MONITOR_EN
      good_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      srst_q  <= srst_d;
      pon_q   <= pon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
`ifdef SAMPA_PON_PG_MONITOR_EN
      good_q  <= good_d;
`endif
    end
  end

  assign pwr_en    = en_q;
  assign sampa_rst = srst_q;
  assign sampa_pon = pon_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign err_chip  = ec_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sampa_pon_sequencer.sv
// Scoreboard bench: expected pin-change events are queued by the
// stimulus and matched by a monitor on every output change.
module tb_sampa_pon_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] chip_mask = 4'h0;
  logic [3:0] pwr_good;
  logic [3:0] pwr_en, sampa_rst, sampa_pon;
  logic       busy, done, error;
  logic [3:0] err_chip;
  logic [2:0] state_o;

  sampa_pon_sequencer #(
    .N_CHIP(4), .CNT_W(24),
    .T_PG_TMO(16), .T_SETTLE(8), .T_RST(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .start(start), .abort(abort),
    .chip_mask(chip_mask), .pwr_good(pwr_good),
    .pwr_en(pwr_en), .sampa_rst(sampa_rst),
    .sampa_pon(sampa_pon), .busy(busy), .done(done),
    .error(error), .err_chip(err_chip), .state_o(state_o)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Regulator model: power-good follows pwr_en three cycles later.
  logic [3:0] d1 = 0, d2 = 0, d3 = 0;
  logic [3:0] stuck = 0, drop = 0;
  always @(posedge ACLK) begin
    d1 <= pwr_en; d2 <= d1; d3 <= d2;
  end
  assign pwr_good = d3 & ~stuck & ~drop;

  typedef struct {
    int          cyc;
    logic [18:0] pins;
    logic [2:0]  st;
    string       nm;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;

  logic [3:0] m_en, m_rst, m_pon, m_ec;
  logic       m_busy, m_done, m_err;

  task automatic m_reset();
    m_en = 0; m_rst = 4'hF; m_pon = 0;
    m_busy = 0; m_done = 0; m_err = 0; m_ec = 0;
  endtask

  task automatic ev(input string nm, input int c, input logic [2:0] st);
    exp_t e;
    e.cyc  = c;
    e.pins = {m_en, m_rst, m_pon, m_busy, m_done, m_err, m_ec};
    e.st   = st;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // pwr_en at b, reset release 12 later, PON 4 after that.
  task automatic chip_up(input int i, input int b);
    m_en[i] = 1'b1;  ev($sformatf("pwr_en%0d", i), b, 3'd2);
    m_rst[i] = 1'b0; ev($sformatf("rst_rel%0d", i), b + 12, 3'd4);
    m_pon[i] = 1'b1; ev($sformatf("pon%0d", i), b + 16, 3'd5);
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) @(negedge ACLK);
  endtask

  task automatic do_abort();
    @(negedge ACLK);
    m_reset();
    ev("abort", cyc + 1, 3'd0);
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    repeat (6) @(negedge ACLK);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    @(negedge ACLK);
    chip_mask = m; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  logic [18:0] prev, cur;

  always @(negedge ACLK) begin
    if (mon_on) begin
      cur = {pwr_en, sampa_rst, sampa_pon, busy, done, error, err_chip};
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d pins got %h state %0d",
                   cyc, cur, state_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cur !== e.pins || state_o !== e.st || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s cyc got %0d exp %0d pins got %h exp %h state got %0d exp %0d",
                     e.nm, cyc, e.cyc, cur, e.pins, state_o, e.st);
          end
        end
        prev = cur;
      end
      if (sb.size() != 0 && cyc > sb[0].cyc + 4) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s missing: expected at cyc %0d pins %h, now cyc %0d",
                 e.nm, e.cyc, e.pins, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    m_reset();
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({pwr_en, sampa_rst, sampa_pon, busy, done, error, err_chip, state_o}
        !== {4'h0, 4'hF, 4'h0, 3'b000, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got %h/%h/%h b%b d%b e%b c%0d s%0d",
               pwr_en, sampa_rst, sampa_pon, busy, done, error,
               err_chip, state_o);
    end
    prev = {4'h0, 4'hF, 4'h0, 3'b000, 4'h0};
    mon_on = 1;

    // Full bring-up of all four chips.
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy", s, 3'd1);
    for (int i = 0; i < 4; i++) chip_up(i, s + 1 + 18 * i);
    m_busy = 0; m_done = 1; ev("done", s + 72, 3'd6);
    chip_mask = 4'hF; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 76);

    // One-cycle power-good glitch on chip 1 while DONE.
    @(negedge ACLK);
`ifdef SAMPA_PON_PG_MONITOR_EN
    m_en[1] = 0; m_pon[1] = 0; m_rst[1] = 1;
    m_err = 1; m_ec = 4'd1; m_done = 0;
    ev("pg_drop", cyc + 1, 3'd7);
`endif
    drop = 4'b0010;
    @(negedge ACLK);
    drop = 4'b0000;
    repeat (8) @(negedge ACLK);
    do_abort();

    // Sparse mask: chips 0 and 2 only.
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy", s, 3'd1);
    chip_up(0, s + 1);
    chip_up(2, s + 21);
    m_busy = 0; m_done = 1; ev("done", s + 40, 3'd6);
    chip_mask = 4'b0101; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 44);
    do_abort();

    // Chip 2 never reports power-good.
    stuck = 4'b0100;
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy", s, 3'd1);
    chip_up(0, s + 1);
    chip_up(1, s + 19);
    m_en[2] = 1; ev("pwr_en2", s + 37, 3'd2);
    m_en[2] = 0; m_busy = 0; m_err = 1; m_ec = 4'd2;
    ev("timeout", s + 53, 3'd7);
    chip_mask = 4'hF; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 57);
    pulse_start(4'hF);
    repeat (6) @(negedge ACLK);
    do_abort();
    stuck = 4'b0000;

    // Abort with start during chip 1 settle, then re-run.
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy", s, 3'd1);
    chip_up(0, s + 1);
    m_en[1] = 1; ev("pwr_en1", s + 19, 3'd2);
    chip_mask = 4'hF; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 25);
    m_reset();
    ev("abort_settle", s + 26, 3'd0);
    abort = 1'b1; start = 1'b1;
    @(negedge ACLK);
    abort = 1'b0; start = 1'b0;
    repeat (6) @(negedge ACLK);
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy_rerun", s, 3'd1);
    chip_up(0, s + 1);
    m_busy = 0; m_done = 1; ev("done_rerun", s + 24, 3'd6);
    chip_mask = 4'b0001; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 28);
    do_abort();

    // Empty mask, then start ignored in DONE.
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy_m0", s, 3'd1);
    m_busy = 0; m_done = 1; ev("done_m0", s + 8, 3'd6);
    chip_mask = 4'h0; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 12);
    pulse_start(4'hF);
    repeat (6) @(negedge ACLK);
    do_abort();

    // ARESET in the middle of chip 1 power-good wait.
    @(negedge ACLK);
    s = cyc + 1;
    m_busy = 1; ev("busy", s, 3'd1);
    chip_up(0, s + 1);
    m_en[1] = 1; ev("pwr_en1", s + 19, 3'd2);
    chip_mask = 4'hF; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    idle_to(s + 22);
    m_reset();
    ev("areset", s + 23, 3'd0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (10) @(negedge ACLK);

    mon_on = 0;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never seen, expected at cyc %0d", e.nm, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
